// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage : regfile_pkg

// File: rtl/mux32_1.sv
// Single-bit 32:1 multiplexer cell used for register read selection.
module mux32_1
    import regfile_pkg::*;
(
    input  logic [NUM_REGS-1:0] in_i,
    input  reg_idx_t            sel_i,
    output logic                out_o
);

    assign out_o = in_i[sel_i];

endmodule : mux32_1

// File: rtl/regfile_dff.sv
// WIDTH-bit storage register with synchronous active-high reset and write enable.
module regfile_dff #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: load on enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    // State register; reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : regfile_dff

// File: rtl/regfile_bypass.sv
// 32-entry register file: two combinational read ports with same-cycle
// write-to-read bypass, one synchronous write port. X31 reads as zero.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-2:0]            wr_en;

    // Per-bit columns: col[b][r] is bit b of register r, feeding one mux cell.
    logic [WIDTH-1:0][NUM_REGS-1:0] col;
    logic [WIDTH-1:0]               mux1;
    logic [WIDTH-1:0]               mux2;
    logic                           byp1;
    logic                           byp2;

    // X31 has no storage; its mux inputs are tied low.
    assign regs[NUM_REGS-1] = '0;

    // Write decode and storage for X0..X30; X31 has no enable, so writes to it vanish.
    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_regs
        assign wr_en[r] = RegWrite && (WriteRegister == reg_idx_t'(r));

        regfile_dff #(
            .WIDTH(WIDTH)
        ) u_dff (
            .clk  (clk),
            .reset(reset),
            .en_i (wr_en[r]),
            .d_i  (WriteData),
            .q_o  (regs[r])
        );
    end

    // Read selection: one 32:1 mux cell per bit per port.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bits
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
            assign col[b][r] = regs[r][b];
        end

        mux32_1 u_mux1 (
            .in_i (col[b]),
            .sel_i(ReadRegister1),
            .out_o(mux1[b])
        );

        mux32_1 u_mux2 (
            .in_i (col[b]),
            .sel_i(ReadRegister2),
            .out_o(mux2[b])
        );
    end

    // Bypass detection per port; X31 is excluded so it keeps reading zero.
    always_comb begin
        byp1 = RegWrite && (ReadRegister1 == WriteRegister) && (WriteRegister != ZERO_REG);
        byp2 = RegWrite && (ReadRegister2 == WriteRegister) && (WriteRegister != ZERO_REG);
    end

    // Final 2:1 select between stored contents and the in-flight write value.
    always_comb begin
        ReadData1 = byp1 ? WriteData : mux1;
        ReadData2 = byp2 ? WriteData : mux2;
    end

endmodule : regfile_bypass

// File: tb/tb_regfile_bypass.sv
// Directed and randomized self-checking bench for regfile_bypass.
module tb_regfile_bypass;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [W-1:0] model [32];

    regfile_bypass #(
        .WIDTH(W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, updating the reference model from the current inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
        #1;
    endtask

    function automatic logic [W-1:0] expect_rd(input logic [4:0] idx);
        if (idx == 5'd31) return '0;
        if (RegWrite && idx == WriteRegister && WriteRegister != 5'd31) return WriteData;
        return model[idx];
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 'x;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check("reset_rd1", ReadData1, 64'h0);
            check("reset_rd2", ReadData2, 64'h0);
        end

        // Plain write then read.
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0123_4567;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
        #1;
        check("x5_rd1", ReadData1, 64'hDEAD_BEEF_0123_4567);
        check("x6_rd2", ReadData2, 64'h0);

        // Write to X31 is discarded and never bypassed.
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        check("x31_during_rd1", ReadData1, 64'h0);
        check("x31_during_rd2", ReadData2, 64'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("x31_after_rd1", ReadData1, 64'h0);
        check("x31_after_rd2", ReadData2, 64'h0);

        // Bypass: disabled first (prior value), then enabled, across the edge.
        RegWrite = 1'b0; WriteRegister = 5'd12; WriteData = 64'h1234;
        ReadRegister1 = 5'd12; ReadRegister2 = 5'd12;
        #1;
        check("nobyp_rd1", ReadData1, 64'h0);
        check("nobyp_rd2", ReadData2, 64'h0);
        RegWrite = 1'b1;
        #1;
        check("byp_pre_rd1", ReadData1, 64'h1234);
        check("byp_pre_rd2", ReadData2, 64'h1234);
        tick();
        RegWrite = 1'b0;
        #1;
        check("byp_post_rd1", ReadData1, 64'h1234);
        check("byp_post_rd2", ReadData2, 64'h1234);

        // Back-to-back writes to the same register: each bypasses, last wins.
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1111;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd12;
        #1;
        check("b2b_first_rd1", ReadData1, 64'h1111);
        tick();
        WriteData = 64'h2222;
        #1;
        check("b2b_second_rd1", ReadData1, 64'h2222);
        check("b2b_other_rd2", ReadData2, 64'h1234);
        tick();
        RegWrite = 1'b0;
        #1;
        check("b2b_final_rd1", ReadData1, 64'h2222);

        // Reset concurrent with a write of X3.
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hAA;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd5;
        #1;
        check("rst_byp_rd1", ReadData1, 64'hAA);
        check("rst_stored_rd2", ReadData2, 64'hDEAD_BEEF_0123_4567);
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        check("rst_x3_rd1", ReadData1, 64'h0);
        check("rst_x5_rd2", ReadData2, 64'h0);
        RegWrite = 1'b1; WriteData = 64'hBB;
        tick();
        RegWrite = 1'b0;
        #1;
        check("post_rst_x3_rd1", ReadData1, 64'hBB);

        // Randomized run against the reference array model.
        for (int c = 0; c < 1000; c++) begin
            RegWrite      = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData     = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            #1;
            check("rand_rd1", ReadData1, expect_rd(ReadRegister1));
            check("rand_rd2", ReadData2, expect_rd(ReadRegister2));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_bypass
